alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Operand-fetch pipeline stage directly upstream of the ALU. Holds the architectural register file, reads two source registers, optionally substitutes an immediate for the second operand, and presents registered `a`, `b` and `select` to the ALU behind a valid/ready handshake. Also accepts the write-back port that updates the register file.

## Interface
Parameters:
- DATA_W, 32, operand/register width (ALU `a`/`b` width)
- REG_CNT, 32, number of architectural registers
- ADDR_W, 5, register index width; REG_CNT = 2^ADDR_W
- SEL_W, 4, ALU operation select width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream presents an operand request
- in_ready  out  1  stage can accept a request this cycle
- rs1  in  ADDR_W  source register for operand a
- rs2  in  ADDR_W  source register for operand b
- imm  in  DATA_W  immediate value
- use_imm  in  1  1: b = imm; 0: b = reg[rs2]
- sel_in  in  SEL_W  ALU operation code, passed through
- out_valid  out  1  a/b/select valid for the ALU
- out_ready  in  1  ALU side consumes the current operands
- a  out  DATA_W  operand a
- b  out  DATA_W  operand b
- select  out  SEL_W  ALU operation select
- wb_en  in  1  write-back enable
- wb_addr  in  ADDR_W  write-back register index
- wb_data  in  DATA_W  write-back data

## Operation
- Register file: REG_CNT × DATA_W flops. Register 0 reads as 0 always; writes to index 0 ignored.
- Write: on rising clk with wb_en=1 and wb_addr≠0, reg[wb_addr] ← wb_data.
- Output slot: one-entry pipeline register holding {a, b, select, out_valid}.
- in_ready = !out_valid || out_ready (combinational; slot empty or draining this cycle).
- Accept: in_valid && in_ready at rising edge → a ← read(rs1), b ← use_imm ? imm : read(rs2), select ← sel_in, out_valid ← 1.
- Drain only: out_valid && out_ready && !(in_valid) → out_valid ← 0; a/b/select hold last values.
- Stall: out_valid && !out_ready → slot holds all fields unchanged; in_ready=0; upstream must hold its request.
- States (implicit in out_valid): EMPTY (0) and FULL (1). EMPTY→FULL on accept; FULL→FULL on accept while draining, or on stall; FULL→EMPTY on drain without accept.
- read(x): see Configuration for same-cycle write behaviour.
- No arithmetic in the block; values pass bit-exact at DATA_W.

## Timing
- Latency: request accepted at edge N → operands visible on a/b/select after edge N, out_valid=1 in cycle N+1.
- Throughput: one request per cycle when out_ready held 1.
- Reset (rst_n=0, any time, async): all registers 0, out_valid=0, a=0, b=0, select=0. in_ready=1 as soon as reset is asserted. An in-flight request in the slot is discarded; any write-back in that cycle is lost.
- Write-back and a stalled slot: held a/b are NOT refreshed by later writes; the slot keeps the values captured at accept.
- Simultaneous write to rs1 and rs2 both equal to wb_addr: both operands follow the same read rule.

## Configuration
- OPERAND_BYPASS_EN defined: read(x) returns wb_data when wb_en=1, wb_addr=x and x≠0 in the same cycle as the accept (write-to-read forwarding).
- Undefined: read(x) returns the register contents before the edge (old value); the new value is visible to requests accepted from the next cycle onward.
- Register-0 rule holds in both builds.

## Structure
- Shared package `cpu_pkg`: DATA_W, ADDR_W, SEL_W, REG_CNT constants and the ALU select code constants (same codes the ALU decodes).
- One sub-module: `reg_file` (storage, write port, two combinational read ports with optional bypass); `alu_operand_stage` holds the slot and handshake.

## Test plan
- Reset: assert rst_n=0 mid-stream with out_valid=1 → out_valid=0, a=b=select=0 immediately; after release, read reg 7 → a=0.
- Write/read: wb reg3=0x0000_0005, then next cycle rs1=3, rs2=0, sel_in=2 → a=5, b=0, select=2, out_valid=1 one cycle later.
- Register 0: wb_en=1, wb_addr=0, wb_data=0xFFFF_FFFF; then rs1=0 → a=0.
- Immediate: reg4=9, rs1=4, use_imm=1, imm=1, sel_in=1 → a=9, b=1; rs2 ignored.
- Stall/back-pressure: out_ready=0 with slot FULL (a=1,b=1) and in_valid=1 → in_ready=0, outputs hold 3 cycles; during stall write reg rs1=0x77 → a stays 1; out_ready=1 → pending request accepted the same edge, next operands appear.
- Same-cycle write+read: reg6=1, accept rs1=6 while wb reg6=0x10 → a=0x10 with OPERAND_BYPASS_EN, a=1 without.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, ALU select codes and the operand-slot state type.
package cpu_pkg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int SEL_W   = 4;
  localparam int REG_CNT = 1 << ADDR_W;

  // Operation codes decoded by the downstream ALU
  localparam logic [SEL_W-1:0] ALU_ADD = 4'd0;
  localparam logic [SEL_W-1:0] ALU_SUB = 4'd1;
  localparam logic [SEL_W-1:0] ALU_AND = 4'd2;
  localparam logic [SEL_W-1:0] ALU_OR  = 4'd3;
  localparam logic [SEL_W-1:0] ALU_XOR = 4'd4;
  localparam logic [SEL_W-1:0] ALU_SLL = 4'd5;
  localparam logic [SEL_W-1:0] ALU_SRL = 4'd6;
  localparam logic [SEL_W-1:0] ALU_SRA = 4'd7;
  localparam logic [SEL_W-1:0] ALU_SLT = 4'd8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Bundle of request, operand-delivery and write-back signals around the ALU operand stage.
interface alu_operand_stage_if #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int SEL_W  = cpu_pkg::SEL_W
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [DATA_W-1:0] imm;
  logic              use_imm;
  logic [SEL_W-1:0]  sel_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [SEL_W-1:0]  select;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output in_valid, rs1, rs2, imm, use_imm, sel_in, out_ready, wb_en, wb_addr, wb_data,
    input  in_ready, out_valid, a, b, select
  );

  modport slave (
    input  in_valid, rs1, rs2, imm, use_imm, sel_in, out_ready, wb_en, wb_addr, wb_data,
    output in_ready, out_valid, a, b, select
  );
endinterface

// File: rtl/alu_operand_stage_reg_file.sv
// Architectural register file: one write port, two combinational read ports, r0 hardwired to zero.
// Build option OPERAND_BYPASS_EN forwards same-cycle write-back data to the read ports.
module reg_file #(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int REG_CNT = cpu_pkg::REG_CNT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  logic [DATA_W-1:0] regs [REG_CNT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

`ifdef OPERAND_BYPASS_EN
  // A write landing on the same edge as the read is forwarded so the consumer sees the new value
  assign rd1 = (rs1 == '0) ? '0 : (wb_en && (wb_addr == rs1)) ? wb_data : regs[rs1];
  assign rd2 = (rs2 == '0) ? '0 : (wb_en && (wb_addr == rs2)) ? wb_data : regs[rs2];
`else
  assign rd1 = (rs1 == '0) ? '0 : regs[rs1];
  assign rd2 = (rs2 == '0) ? '0 : regs[rs2];
`endif

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage ahead of the ALU: register-file read, immediate select and a one-entry output slot.
// Define OPERAND_BYPASS_EN to forward same-cycle write-back data into the operands.
module alu_operand_stage #(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int SEL_W   = cpu_pkg::SEL_W,
  parameter int REG_CNT = cpu_pkg::REG_CNT
) (
  input logic                clk,
  input logic                rst_n,
  alu_operand_stage_if.slave bus
);
  import cpu_pkg::*;

  slot_state_t       state_q, state_d;
  logic [DATA_W-1:0] rd1_p0, rd2_p0;
  logic [DATA_W-1:0] b_p0;
  logic              accept_p0;
  logic [DATA_W-1:0] a_p1, b_p1;
  logic [SEL_W-1:0]  sel_p1;
  logic              vld_p1;

  reg_file #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .REG_CNT (REG_CNT)
  ) u_reg_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .wb_en   (bus.wb_en),
    .wb_addr (bus.wb_addr),
    .wb_data (bus.wb_data),
    .rs1     (bus.rs1),
    .rs2     (bus.rs2),
    .rd1     (rd1_p0),
    .rd2     (rd2_p0)
  );

  assign vld_p1    = (state_q == SLOT_FULL);
  assign accept_p0 = bus.in_valid && bus.in_ready;
  assign b_p0      = bus.use_imm ? bus.imm : rd2_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SLOT_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (accept_p0) state_d = SLOT_FULL;
      SLOT_FULL:  if (!accept_p0 && bus.out_ready) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  // p0 -> p1: capture operands on accept; they hold through stalls and after draining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p1   <= '0;
      b_p1   <= '0;
      sel_p1 <= '0;
    end else if (accept_p0) begin
      a_p1   <= rd1_p0;
      b_p1   <= b_p0;
      sel_p1 <= bus.sel_in;
    end
  end

  assign bus.in_ready  = !vld_p1 || bus.out_ready;
  assign bus.out_valid = vld_p1;
  assign bus.a         = a_p1;
  assign bus.b         = b_p1;
  assign bus.select    = sel_p1;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage; expectations follow OPERAND_BYPASS_EN.
module tb_alu_operand_stage;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_operand_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEL_W(SEL_W)) bus ();

  alu_operand_stage #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .SEL_W   (SEL_W),
    .REG_CNT (REG_CNT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.rs1      = '0;
    bus.rs2      = '0;
    bus.imm      = '0;
    bus.use_imm  = 1'b0;
    bus.sel_in   = '0;
    bus.wb_en    = 1'b0;
    bus.wb_addr  = '0;
    bus.wb_data  = '0;
  endtask

  task automatic write_reg(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    bus.wb_en   = 1'b1;
    bus.wb_addr = addr;
    bus.wb_data = data;
    cyc();
    bus.wb_en   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    cyc();
    cyc();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    checks++;
    if (bus.a !== 32'h0 || bus.b !== 32'h0 || bus.select !== 4'h0) begin
      failures++; $display("FAIL reset_operands got a=%h b=%h sel=%h exp all 0", bus.a, bus.b, bus.select);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_write_read();
    write_reg(5'd3, 32'h0000_0005);
    bus.in_valid = 1'b1; bus.rs1 = 5'd3; bus.rs2 = 5'd0; bus.sel_in = 4'd2; bus.use_imm = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL wr_empty_before got=%b exp=0", bus.out_valid);
    end
    cyc();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.a !== 32'h5 || bus.b !== 32'h0 || bus.select !== 4'd2) begin
      failures++; $display("FAIL wr_read got v=%b a=%h b=%h sel=%h exp v=1 a=5 b=0 sel=2",
                           bus.out_valid, bus.a, bus.b, bus.select);
    end
    cyc();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.a !== 32'h5) begin
      failures++; $display("FAIL wr_drain got v=%b a=%h exp v=0 a=5", bus.out_valid, bus.a);
    end
  endtask

  task automatic test_reg0();
    write_reg(5'd0, 32'hFFFF_FFFF);
    bus.in_valid = 1'b1; bus.rs1 = 5'd0; bus.rs2 = 5'd0; bus.sel_in = 4'd0;
    cyc();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.a !== 32'h0 || bus.b !== 32'h0) begin
      failures++; $display("FAIL reg0 got a=%h b=%h exp 0 0", bus.a, bus.b);
    end
    cyc();
  endtask

  task automatic test_imm();
    write_reg(5'd4, 32'h0000_0009);
    write_reg(5'd5, 32'h0000_AAAA);
    bus.in_valid = 1'b1; bus.rs1 = 5'd4; bus.rs2 = 5'd5; bus.use_imm = 1'b1;
    bus.imm = 32'h0000_0001; bus.sel_in = 4'd1;
    cyc();
    bus.in_valid = 1'b0; bus.use_imm = 1'b0;
    checks++;
    if (bus.a !== 32'h9 || bus.b !== 32'h1 || bus.select !== 4'd1) begin
      failures++; $display("FAIL imm got a=%h b=%h sel=%h exp a=9 b=1 sel=1", bus.a, bus.b, bus.select);
    end
    cyc();
  endtask

  task automatic test_stall();
    write_reg(5'd1, 32'h0000_0001);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.rs1 = 5'd1; bus.rs2 = 5'd1; bus.sel_in = 4'd3;
    cyc();
    bus.rs2 = 5'd0; bus.sel_in = 4'd4;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd1; bus.wb_data = 32'h0000_0077;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.a !== 32'h1 ||
          bus.b !== 32'h1 || bus.select !== 4'd3) begin
        failures++; $display("FAIL stall_hold[%0d] got rdy=%b v=%b a=%h b=%h sel=%h exp rdy=0 v=1 a=1 b=1 sel=3",
                             i, bus.in_ready, bus.out_valid, bus.a, bus.b, bus.select);
      end
      cyc();
      bus.wb_en = 1'b0;
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL stall_release_ready got=%b exp=1", bus.in_ready);
    end
    cyc();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.a !== 32'h77 || bus.b !== 32'h0 || bus.select !== 4'd4) begin
      failures++; $display("FAIL stall_next got v=%b a=%h b=%h sel=%h exp v=1 a=77 b=0 sel=4",
                           bus.out_valid, bus.a, bus.b, bus.select);
    end
    cyc();
  endtask

  task automatic test_same_cycle();
    logic [DATA_W-1:0] exp_v;
`ifdef OPERAND_BYPASS_EN
    exp_v = 32'h0000_0010;
`else
    exp_v = 32'h0000_0001;
`endif
    write_reg(5'd6, 32'h0000_0001);
    bus.in_valid = 1'b1; bus.rs1 = 5'd6; bus.rs2 = 5'd6; bus.sel_in = 4'd5;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd6; bus.wb_data = 32'h0000_0010;
    cyc();
    bus.wb_en = 1'b0;
    checks++;
    if (bus.a !== exp_v || bus.b !== exp_v) begin
      failures++; $display("FAIL same_cycle got a=%h b=%h exp %h %h", bus.a, bus.b, exp_v, exp_v);
    end
    cyc();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.a !== 32'h10) begin
      failures++; $display("FAIL same_cycle_after got a=%h exp 10", bus.a);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] vals [3];
    logic [DATA_W-1:0] imms [3];
    vals[0] = 32'h8000_0001; vals[1] = 32'hDEAD_BEEF; vals[2] = 32'h0000_00A5;
    imms[0] = 32'h1234_5678; imms[1] = 32'hFFFF_0000; imms[2] = 32'h0000_0003;
    for (int i = 0; i < 3; i++) write_reg(5'(8 + i), vals[i]);
    bus.in_valid = 1'b1; bus.use_imm = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.rs1 = 5'(8 + i); bus.imm = imms[i]; bus.sel_in = 4'(6 + i);
      cyc();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.a !== vals[i] ||
          bus.b !== imms[i] || bus.select !== 4'(6 + i)) begin
        failures++; $display("FAIL b2b[%0d] got v=%b rdy=%b a=%h b=%h sel=%h exp v=1 rdy=1 a=%h b=%h sel=%h",
                             i, bus.out_valid, bus.in_ready, bus.a, bus.b, bus.select, vals[i], imms[i], 4'(6 + i));
      end
    end
    bus.in_valid = 1'b0; bus.use_imm = 1'b0;
    cyc();
  endtask

  task automatic test_reset_midstream();
    write_reg(5'd7, 32'h0000_1234);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.rs1 = 5'd7; bus.rs2 = 5'd7; bus.sel_in = 4'd9;
    cyc();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.a !== 32'h1234) begin
      failures++; $display("FAIL mid_full got v=%b a=%h exp v=1 a=1234", bus.out_valid, bus.a);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.a !== 32'h0 || bus.b !== 32'h0 ||
        bus.select !== 4'h0 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL mid_reset got v=%b a=%h b=%h sel=%h rdy=%b exp v=0 a=0 b=0 sel=0 rdy=1",
                           bus.out_valid, bus.a, bus.b, bus.select, bus.in_ready);
    end
    cyc();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.rs1 = 5'd7; bus.rs2 = 5'd0; bus.sel_in = 4'd0;
    cyc();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.a !== 32'h0) begin
      failures++; $display("FAIL mid_after_reg7 got v=%b a=%h exp v=1 a=0", bus.out_valid, bus.a);
    end
    cyc();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    test_reset();
    test_write_read();
    test_reg0();
    test_imm();
    test_stall();
    test_same_cycle();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
